// File: rtl/con3_motion_ctrl.sv
// Motion sequencer for the CON3 servo interface: holds one pending target-angle
// command, slews the angle once per frame by a per-command step, dwells, then pulses done.
module con3_motion_ctrl #(
    parameter int unsigned FRAME_CYCLES = 400000,
    parameter int unsigned DWELL_FRAMES = 2,
    parameter logic [7:0]  MIN_ANGLE    = 8'd0,
    parameter logic [7:0]  MAX_ANGLE    = 8'd255,
    parameter logic [7:0]  INIT_ANGLE   = 8'd128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_angle,
    input  logic [7:0] cmd_step,
    output logic [7:0] angle,
    output logic       servo_en,
    output logic       frame_tick,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W      = $clog2(FRAME_CYCLES);
    localparam int unsigned DW_W       = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam int unsigned DWELL_LAST = (DWELL_FRAMES > 0) ? DWELL_FRAMES - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_DWELL = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       angle_q, angle_d;
    logic [7:0]       target_q, target_d;
    logic [7:0]       step_q, step_d;
    logic             pend_valid_q, pend_valid_d;
    logic [7:0]       pend_angle_q, pend_angle_d;
    logic [7:0]       pend_step_q, pend_step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic             done_q, done_d;
    logic             servo_en_q;
    logic [8:0]       diff;

    // Signed compare keeps the clamp free of constant-result comparisons at the range ends
    function automatic logic [7:0] clamp_angle(input logic [7:0] a);
        if (int'(a) < int'(MIN_ANGLE)) return MIN_ANGLE;
        if (int'(a) > int'(MAX_ANGLE)) return MAX_ANGLE;
        return a;
    endfunction

    assign frame_tick = enable & (cnt_q == CNT_W'(FRAME_CYCLES - 1));
    assign cmd_ready  = enable & ~pend_valid_q;
    assign busy       = (state_q != ST_IDLE) | pend_valid_q;
    assign angle      = angle_q;
    assign servo_en   = servo_en_q;
    assign done       = done_q;
    assign diff       = (target_q >= angle_q) ? ({1'b0, target_q} - {1'b0, angle_q})
                                              : ({1'b0, angle_q} - {1'b0, target_q});

    // Next-state: frame counter, pending slot, move sequencing
    always_comb begin
        state_d      = state_q;
        angle_d      = angle_q;
        target_d     = target_q;
        step_d       = step_q;
        pend_valid_d = pend_valid_q;
        pend_angle_d = pend_angle_q;
        pend_step_d  = pend_step_q;
        cnt_d        = cnt_q;
        dwell_d      = dwell_q;
        done_d       = 1'b0;

        if (!enable) begin
            state_d      = ST_IDLE;
            pend_valid_d = 1'b0;
            cnt_d        = '0;
            dwell_d      = '0;
        end else begin
            cnt_d = frame_tick ? '0 : cnt_q + CNT_W'(1);

            if (cmd_valid && cmd_ready) begin
                pend_valid_d = 1'b1;
                pend_angle_d = clamp_angle(cmd_angle);
                pend_step_d  = cmd_step;
            end

            case (state_q)
                ST_IDLE: begin
                    if (pend_valid_q) begin
                        target_d     = pend_angle_q;
                        step_d       = pend_step_q;
                        pend_valid_d = 1'b0;
                        state_d      = ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    if (frame_tick) begin
                        if (step_q == 8'd0 || diff <= {1'b0, step_q}) begin
                            angle_d = target_q;
                            dwell_d = '0;
                            if (DWELL_FRAMES == 0) begin
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_DWELL;
                            end
                        end else if (target_q > angle_q) begin
                            angle_d = angle_q + step_q;
                        end else begin
                            angle_d = angle_q - step_q;
                        end
                    end
                end
                ST_DWELL: begin
                    if (frame_tick) begin
                        if (dwell_q == DW_W'(DWELL_LAST)) begin
                            done_d  = 1'b1;
                            dwell_d = '0;
                            state_d = ST_IDLE;
                        end else begin
                            dwell_d = dwell_q + DW_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers; angle survives disable, only rst restores it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            angle_q      <= INIT_ANGLE;
            target_q     <= INIT_ANGLE;
            step_q       <= 8'd0;
            pend_valid_q <= 1'b0;
            pend_angle_q <= 8'd0;
            pend_step_q  <= 8'd0;
            cnt_q        <= '0;
            dwell_q      <= '0;
            done_q       <= 1'b0;
            servo_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            angle_q      <= angle_d;
            target_q     <= target_d;
            step_q       <= step_d;
            pend_valid_q <= pend_valid_d;
            pend_angle_q <= pend_angle_d;
            pend_step_q  <= pend_step_d;
            cnt_q        <= cnt_d;
            dwell_q      <= dwell_d;
            done_q       <= done_d;
            servo_en_q   <= enable;
        end
    end

endmodule

// File: tb/tb_con3_motion_ctrl.sv
// Scoreboard bench for con3_motion_ctrl: a move-level model predicts angle steps and
// completion timing; a negedge monitor pops and compares as the DUT produces them.
module tb_con3_motion_ctrl;

    localparam int FC    = 10;
    localparam int DW    = 2;
    localparam int MINA  = 20;
    localparam int MAXA  = 230;
    localparam int INITA = 128;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_angle;
    logic [7:0] cmd_step;
    logic [7:0] angle;
    logic       servo_en;
    logic       frame_tick;
    logic       busy;
    logic       done;

    con3_motion_ctrl #(
        .FRAME_CYCLES(FC),
        .DWELL_FRAMES(DW),
        .MIN_ANGLE   (8'(MINA)),
        .MAX_ANGLE   (8'(MAXA)),
        .INIT_ANGLE  (8'(INITA))
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_angle (cmd_angle),
        .cmd_step  (cmd_step),
        .angle     (angle),
        .servo_en  (servo_en),
        .frame_tick(frame_tick),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int final_angle;
        int ticks;
    } move_t;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } chk_t;

    int    exp_angles[$];
    move_t exp_moves[$];
    chk_t  chk_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int model_base  = INITA;
    int model_cur   = INITA;
    int flush_req   = 0;
    int flush_seen  = 0;

    logic  rst_seen   = 1'b1;
    int    prev_angle = INITA;
    logic  prev_busy  = 1'b0;
    int    ticks      = 0;
    int    e_angle;
    move_t m_pop;
    chk_t  c_pop;

    always @(posedge clk) rst_seen <= rst;

    function automatic void compare(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Monitor: drains directed checks, pops expected angle steps and completions
    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            c_pop = chk_q.pop_front();
            compare(c_pop.name, c_pop.act, c_pop.exp);
        end
        if (rst_seen || flush_req != flush_seen) begin
            exp_angles.delete();
            exp_moves.delete();
            ticks      = 0;
            flush_seen = flush_req;
            if (rst_seen) model_cur = INITA;
        end else begin
            if (int'(angle) != prev_angle) begin
                compare("angle_change_expected", int'(exp_angles.size() > 0), 1);
                if (exp_angles.size() > 0) begin
                    e_angle = exp_angles.pop_front();
                    compare("angle_step", int'(angle), e_angle);
                    model_cur = e_angle;
                end
            end
            if (frame_tick && busy && !done && prev_busy) ticks++;
            if (done) begin
                compare("done_expected", int'(exp_moves.size() > 0), 1);
                if (exp_moves.size() > 0) begin
                    m_pop = exp_moves.pop_front();
                    compare("done_angle", int'(angle), m_pop.final_angle);
                    compare("done_ticks", ticks, m_pop.ticks);
                    compare("busy_at_done", int'(busy), int'(exp_moves.size() > 0));
                end
                ticks = 0;
            end
        end
        prev_angle = int'(angle);
        prev_busy  = busy;
    end

    task automatic chk(input string nm, input int act, input int exp);
        chk_t c;
        c.name = nm;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    // Move-level model: clamp, then step toward target one frame at a time
    task automatic model_push(input int a, input int s);
        int    t, cur, d, n;
        bit    fin;
        move_t m;
        t   = (a < MINA) ? MINA : ((a > MAXA) ? MAXA : a);
        cur = model_base;
        n   = 0;
        fin = 1'b0;
        while (!fin) begin
            n++;
            d = (t > cur) ? t - cur : cur - t;
            if (s == 0 || d <= s) begin
                if (cur != t) exp_angles.push_back(t);
                fin = 1'b1;
            end else begin
                cur = (t > cur) ? cur + s : cur - s;
                exp_angles.push_back(cur);
            end
        end
        m.final_angle = t;
        m.ticks       = n + DW;
        exp_moves.push_back(m);
        model_base = t;
    endtask

    task automatic send(input int a, input int s);
        int cyc;
        bit ok;
        cyc       = 0;
        cmd_angle = 8'(a);
        cmd_step  = 8'(s);
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        ok = cmd_ready;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (ok) model_push(a, s);
        chk("accept_in_time", int'(ok), 1);
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while ((exp_moves.size() != 0 || busy) && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("idle_in_time", int'(cyc < 5000), 1);
    endtask

    task automatic wait_angle(input int v);
        int cyc;
        cyc = 0;
        while (model_cur != v && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("angle_reached_in_time", int'(cyc < 4000), 1);
    endtask

    task automatic disable_now();
        enable = 1'b0;
        @(negedge clk);
        chk("servo_en_lag", int'(servo_en), 1);
        chk("tick_off_when_disabled", int'(frame_tick), 0);
        chk("ready_off_when_disabled", int'(cmd_ready), 0);
        @(negedge clk);
        chk("servo_en_off", int'(servo_en), 0);
        chk("busy_off_when_disabled", int'(busy), 0);
        @(posedge clk);
        #1;
        flush_req++;
        @(posedge clk);
        #1;
        model_base = model_cur;
        chk("angle_held", int'(angle), model_base);
    endtask

    task automatic reenable();
        enable = 1'b1;
        @(negedge clk);
        chk("reenable_busy", int'(busy), 0);
        chk("reenable_ready", int'(cmd_ready), 1);
        chk("reenable_angle", int'(angle), model_base);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors, expected completion", vectors);
        $fatal(1);
    end

    initial begin
        int period, ticks_seen, a, s;
        rst       = 1'b1;
        enable    = 1'b1;
        cmd_valid = 1'b0;
        cmd_angle = 8'd0;
        cmd_step  = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_angle", int'(angle), INITA);
        chk("rst_servo_en", int'(servo_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_tick", int'(frame_tick), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("servo_en_follows", int'(servo_en), 1);

        // Frame period
        period = 0;
        while (!frame_tick && period < 40) begin @(negedge clk); period++; end
        period = 0;
        @(negedge clk);
        period = 1;
        while (!frame_tick && period < 40) begin @(negedge clk); period++; end
        chk("frame_period", period, FC);
        @(posedge clk);
        #1;

        // Jump move; ready is low for exactly the load cycle
        send(200, 0);
        @(negedge clk);
        chk("ready_low_after_accept", int'(cmd_ready), 0);
        @(negedge clk);
        chk("ready_back_after_load", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        wait_idle();
        send(128, 0);
        wait_idle();

        // Ramp down with a queued command behind it
        send(100, 10);
        wait_angle(118);
        send(150, 50);
        @(negedge clk);
        chk("ready_low_while_queued", int'(cmd_ready), 0);
        @(posedge clk);
        #1;
        cmd_angle = 8'd77;
        cmd_step  = 8'd0;
        cmd_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("extra_cmd_refused", int'(cmd_ready), 0);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_idle();
        chk("queued_final", int'(angle), 150);

        // Clamp both ends
        send(250, 0);
        wait_idle();
        chk("clamp_hi", int'(angle), MAXA);
        send(5, 0);
        wait_idle();
        chk("clamp_lo", int'(angle), MINA);

        // Disable mid-ramp with a pending command
        send(128, 0);
        wait_idle();
        send(255, 1);
        wait_angle(131);
        send(90, 0);
        disable_now();
        chk("disable_angle_131", int'(angle), 131);
        ticks_seen = 0;
        repeat (2 * FC) begin
            @(negedge clk);
            if (frame_tick) ticks_seen++;
        end
        chk("no_ticks_disabled", ticks_seen, 0);
        @(posedge clk);
        #1;
        reenable();

        // Randomised moves, queueing and disables
        for (int i = 0; i < 30; i++) begin
            a = int'($urandom_range(0, 255));
            s = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(4, 60));
            send(a, s);
            if ($urandom_range(0, 2) == 0) begin
                a = int'($urandom_range(0, 255));
                s = int'($urandom_range(0, 40));
                send(a, s);
            end
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(5, 60)) @(posedge clk);
                #1;
                disable_now();
                repeat ($urandom_range(1, 8)) @(posedge clk);
                #1;
                reenable();
            end else if ($urandom_range(0, 1) == 0) begin
                wait_idle();
            end
        end
        wait_idle();

        // Reset mid-ramp
        send(128, 0);
        wait_idle();
        send(200, 2);
        wait_angle(132);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_base = INITA;
        @(negedge clk);
        chk("rst_mid_angle", int'(angle), INITA);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ready", int'(cmd_ready), 1);
        chk("rst_mid_done", int'(done), 0);
        chk("rst_mid_servo_en", int'(servo_en), 0);
        @(posedge clk);
        #1;
        send(60, 7);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/con3_motion_ctrl.md
Name: con3_motion_ctrl

Overview:
Motion sequencer that sits in front of the CON3 servo interface and drives its angle and enable inputs. It accepts target-angle commands over a valid/ready handshake and holds one command pending while a move is in progress. It slews the angle toward the target by a per-command step once per servo frame, then dwells for a fixed number of frames before reporting completion.

Parameters:
FRAME_CYCLES, 400000, clk cycles per update frame (≥2).
DWELL_FRAMES, 2, frames held at target before done (0 = no dwell).
MIN_ANGLE, 8'd0, lower clamp for commanded angle.
MAX_ANGLE, 8'd255, upper clamp for commanded angle (≥ MIN_ANGLE).
INIT_ANGLE, 8'd128, angle after reset (within clamp range).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  controller enable; low = disabled
cmd_valid  in  1  command present
cmd_ready  out  1  command slot free
cmd_angle  in  8  target angle
cmd_step  in  8  angle change per frame; 0 = jump straight to target
angle  out  8  angle to servo interface
servo_en  out  1  enable to servo interface
frame_tick  out  1  one-cycle pulse per frame
busy  out  1  move active or pending
done  out  1  one-cycle pulse when a move completes

Behaviour:
- Reset (rst=1 at posedge clk): angle=INIT_ANGLE, servo_en=0, state=IDLE, pending slot empty, frame counter=0, dwell counter=0, done=0.
- servo_en: registered copy of enable, so it has 1 cycle latency.
- Frame counter:
  - Runs 0..FRAME_CYCLES-1 while enable=1 and wraps to 0.
  - Forced to 0 while enable=0.
  - frame_tick = enable & (count == FRAME_CYCLES-1).
- Pending slot (pend_valid, pend_angle, pend_step):
  - cmd_ready = enable & ~pend_valid, combinational from registers.
  - Accept on cmd_valid & cmd_ready. On accept: pend_angle = clamp(cmd_angle, MIN_ANGLE, MAX_ANGLE), pend_step = cmd_step, pend_valid=1.
  - The slot is cleared only when IDLE loads it.
  - Accept and load never occur in the same cycle, because ready is low while the slot is full.
- State machine:
  - IDLE:
    - If pend_valid: target=pend_angle, step=pend_step, clear pend_valid, go to RAMP.
    - A command accepted in cycle N is loaded in cycle N+1.
  - RAMP: acts only on frame_tick.
    - Let diff = |target - angle|, computed unsigned in 9 bits.
    - If step==0 or diff ≤ step: angle=target, then go to DWELL (dwell counter=0). If DWELL_FRAMES==0, pulse done and go to IDLE instead.
    - Otherwise angle = angle ± step toward target. No overflow is possible, because angle never passes target.
    - target==angle at load: completes on the first frame_tick.
  - DWELL: on frame_tick, dwell counter +1. On the tick where the counter reaches DWELL_FRAMES-1, pulse done and go to IDLE.
- Pending during a move: a command accepted during RAMP/DWELL waits in the slot and is loaded in the IDLE cycle right after done. The move in progress is never pre-empted.
- busy = (state != IDLE) | pend_valid.
- done: registered, high for exactly one cycle per completed move.
- enable falling (sync, evaluated each clk):
  - While enable=0: state=IDLE, pending slot cleared (command discarded), counters=0, done=0.
  - angle is retained, not reset.
  - Re-enabling resumes from the retained angle with no pending command.
- rst overrides enable.
- Angle stays within [MIN_ANGLE, MAX_ANGLE] at all times after reset.

Test Plan:
1. Jump move. FRAME_CYCLES=10, DWELL_FRAMES=2, enable=1. Send angle=200, step=0 → cmd_ready drops for 1 cycle; angle=200 on the 1st frame_tick; done pulses on the 3rd frame_tick; busy falls with done.
2. Ramp down. From angle=128, send angle=100, step=10 → angle 118, 108, 100 on successive ticks (final step clipped); done 2 frames later; no undershoot below 100.
3. Clamp. MIN_ANGLE=20, MAX_ANGLE=230. Send angle=250, step=0 → angle settles at 230. Send angle=5 → angle settles at 20.
4. Queued command.
   - During the ramp in scenario 2, send angle=150, step=50 → cmd_ready stays low after accept, and a further cmd_valid is not accepted.
   - After done, the second move starts next cycle: angle 150 on the first tick, then dwell, then done.
5. Disable mid-move. Ramp toward 255 with step 1; drop enable after 3 ticks → angle holds at 131; pending command is cleared; servo_en=0 one cycle later; frame_tick=0.
   - Re-enable → busy=0, angle=131.
6. Reset mid-ramp. Assert rst for 1 cycle → next cycle angle=128, busy=0, cmd_ready=enable, done=0, servo_en=0.
